// File: rtl/apb_global_pkg.sv
// Shared APB bus dimensions and the completer FSM state type.
// Every APB block in the system sizes its bus ports from here.
package apb_global_pkg;

  localparam int ADDRESS_WIDTH = 32;
  localparam int DATA_WIDTH    = 32;
  localparam int NO_OF_SLAVES  = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2
  } apb_slave_state_e;

  // Width of a word index into a storage array of the given depth.
  function automatic int idx_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/apb_slave_regfile.sv
// Word storage with per-byte write enables.
// The last entry is a read-only ID register that reloads on reset.
module apb_slave_regfile
  import apb_global_pkg::idx_bits;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    MEM_DEPTH  = 16,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 32'hA5B0_0001,
  parameter int                    IDX_W      = idx_bits(MEM_DEPTH)
) (
  input  logic                    pclk,
  input  logic                    preset,
  input  logic                    wr_en,
  input  logic [IDX_W-1:0]        wr_idx,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [IDX_W-1:0]        rd_idx,
  output logic [DATA_WIDTH-1:0]   rd_data
);

  localparam int STRB_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] rd_vec [MEM_DEPTH];

  for (genvar gi = 0; gi < MEM_DEPTH; gi++) begin : g_entry
    localparam logic [DATA_WIDTH-1:0] RST_VAL = (gi == MEM_DEPTH - 1) ? ID_VALUE : '0;

    logic [DATA_WIDTH-1:0] entry_q;
    logic [DATA_WIDTH-1:0] entry_d;

    if (gi == MEM_DEPTH - 1) begin : g_id
      // The ID word can never be written; the bus side reports the attempt.
      assign entry_d = ID_VALUE;
    end else begin : g_rw
      always_comb begin
        entry_d = entry_q;
        if (wr_en && (wr_idx == IDX_W'(gi))) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (wr_strb[b]) begin
              entry_d[8*b +: 8] = wr_data[8*b +: 8];
            end
          end
        end
      end
    end

    always_ff @(posedge pclk) begin
      if (preset) begin
        entry_q <= RST_VAL;
      end else begin
        entry_q <= entry_d;
      end
    end

    assign rd_vec[gi] = entry_q;
  end

  always_comb begin
    rd_data = '0;
    if (32'(rd_idx) < MEM_DEPTH) begin
      rd_data = rd_vec[rd_idx];
    end
  end

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer fronting a small word memory with a fixed number of wait states.
// Owns the transfer FSM, address decode and error reporting; storage lives in apb_slave_regfile.
module apb_slave_mem
  import apb_global_pkg::apb_slave_state_e;
  import apb_global_pkg::IDLE;
  import apb_global_pkg::WAIT;
  import apb_global_pkg::ACCESS;
  import apb_global_pkg::idx_bits;
#(
  parameter int                       ADDRESS_WIDTH = apb_global_pkg::ADDRESS_WIDTH,
  parameter int                       DATA_WIDTH    = apb_global_pkg::DATA_WIDTH,
  parameter int                       NO_OF_SLAVES  = apb_global_pkg::NO_OF_SLAVES,
  parameter int                       SLAVE_INDEX   = 0,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = '0,
  parameter int                       MEM_DEPTH     = 16,
  parameter int                       WAIT_STATES   = 2,
  parameter logic [DATA_WIDTH-1:0]    ID_VALUE      = 32'hA5B0_0001
) (
  input  logic                     pclk,
  input  logic                     preset,
  input  logic [NO_OF_SLAVES-1:0]  pselx,
  input  logic                     penable,
  input  logic [ADDRESS_WIDTH-1:0] paddr,
  input  logic                     pwrite,
  input  logic [DATA_WIDTH/8-1:0]  pstrb,
  input  logic [DATA_WIDTH-1:0]    pwdata,
  input  logic [2:0]               pprot,
  output logic                     pready,
  output logic [DATA_WIDTH-1:0]    prdata,
  output logic                     pslverr
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = idx_bits(MEM_DEPTH);

  // Bounds are compared one bit wider so a window at the top of the map cannot wrap.
  localparam logic [ADDRESS_WIDTH:0] ADDR_LO   = {1'b0, BASE_ADDR};
  localparam logic [ADDRESS_WIDTH:0] ADDR_HI   = ADDR_LO + (ADDRESS_WIDTH + 1)'(4 * MEM_DEPTH);
  localparam logic [IDX_W-1:0]       ID_IDX    = IDX_W'(MEM_DEPTH - 1);
  localparam logic [3:0]             WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  apb_slave_state_e state_q, state_d;
  logic [3:0]               cnt_q, cnt_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic                     write_q, write_d;
  logic [STRB_W-1:0]        strb_q, strb_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic                     priv_q, priv_d;
  logic                     pready_q, pready_d;
  logic                     pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0]    prdata_q, prdata_d;

  logic                     sel;
  logic                     access_ok;
  logic [ADDRESS_WIDTH-1:0] txn_addr;
  logic                     txn_write;
  logic                     txn_priv;
  logic [ADDRESS_WIDTH-1:0] offset;
  logic [IDX_W-1:0]         idx;
  logic                     dec_err;
  logic                     wp_err;
  logic                     txn_err;
  logic                     enter_access;
  logic                     wr_en;
  logic [DATA_WIDTH-1:0]    rd_data;
  logic                     unused_bits;

  assign sel       = pselx[SLAVE_INDEX];
  assign access_ok = sel && penable;

  // With no wait states ACCESS is entered from the setup cycle itself, so decode
  // must look at the live bus in IDLE and at the captured copy afterwards.
  assign txn_addr  = (state_q == IDLE) ? paddr    : addr_q;
  assign txn_write = (state_q == IDLE) ? pwrite   : write_q;
  assign txn_priv  = (state_q == IDLE) ? pprot[0] : priv_q;

  assign offset  = txn_addr - BASE_ADDR;
  assign idx     = offset[IDX_W+1:2];
  assign dec_err = ({1'b0, txn_addr} < ADDR_LO) || ({1'b0, txn_addr} >= ADDR_HI) ||
                   (txn_addr[1:0] != 2'b00);
  assign wp_err  = txn_write && ((idx == ID_IDX) || !txn_priv);
  assign txn_err = dec_err || wp_err;

  assign unused_bits = ^{pselx, pprot[2:1], offset};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    write_d      = write_q;
    strb_d       = strb_q;
    wdata_d      = wdata_q;
    priv_d       = priv_q;
    pready_d     = 1'b0;
    pslverr_d    = 1'b0;
    prdata_d     = '0;
    enter_access = 1'b0;
    wr_en        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (sel && !penable) begin
          addr_d  = paddr;
          write_d = pwrite;
          strb_d  = pstrb;
          wdata_d = pwdata;
          priv_d  = pprot[0];
          if (WAIT_STATES == 0) begin
            state_d      = ACCESS;
            enter_access = 1'b1;
          end else begin
            cnt_d   = WAIT_LOAD;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!access_ok) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == 4'd0) begin
          state_d      = ACCESS;
          enter_access = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACCESS: begin
        state_d = IDLE;
        wr_en   = access_ok && write_q && !txn_err;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered, so they are loaded on the edge that enters ACCESS.
    if (enter_access) begin
      pready_d  = 1'b1;
      pslverr_d = txn_err;
      prdata_d  = (txn_err || txn_write) ? '0 : rd_data;
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      strb_q    <= '0;
      wdata_q   <= '0;
      priv_q    <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      strb_q    <= strb_d;
      wdata_q   <= wdata_d;
      priv_q    <= priv_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  apb_slave_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .ID_VALUE   (ID_VALUE),
    .IDX_W      (IDX_W)
  ) u_regfile (
    .pclk    (pclk),
    .preset  (preset),
    .wr_en   (wr_en),
    .wr_idx  (idx),
    .wr_strb (strb_q),
    .wr_data (wdata_q),
    .rd_idx  (idx),
    .rd_data (rd_data)
  );

  assign pready  = pready_q;
  assign pslverr = pslverr_q;
  assign prdata  = prdata_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench: one completer with two wait states, one with none, sharing the bus.
// Expected responses are queued at setup time and popped when pready is seen.
module tb_apb_slave_mem;

  localparam logic [31:0] BASE   = 32'h0000_1000;
  localparam logic [31:0] ID_VAL = 32'hA5B0_0001;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        err;
    int          waits;
  } exp_t;

  logic        clk = 1'b0;
  logic        preset;
  logic [0:0]  psel_a, psel_b;
  logic        penable;
  logic [31:0] paddr;
  logic        pwrite;
  logic [3:0]  pstrb;
  logic [31:0] pwdata;
  logic [2:0]  pprot;
  logic        pready_a, pslverr_a, pready_b, pslverr_b;
  logic [31:0] prdata_a, prdata_b;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  apb_slave_mem #(
    .BASE_ADDR   (BASE),
    .MEM_DEPTH   (16),
    .WAIT_STATES (2),
    .ID_VALUE    (ID_VAL)
  ) u_dut_a (
    .pclk (clk), .preset (preset), .pselx (psel_a), .penable (penable),
    .paddr (paddr), .pwrite (pwrite), .pstrb (pstrb), .pwdata (pwdata),
    .pprot (pprot), .pready (pready_a), .prdata (prdata_a), .pslverr (pslverr_a)
  );

  apb_slave_mem #(
    .BASE_ADDR   (BASE),
    .MEM_DEPTH   (16),
    .WAIT_STATES (0),
    .ID_VALUE    (ID_VAL)
  ) u_dut_b (
    .pclk (clk), .preset (preset), .pselx (psel_b), .penable (penable),
    .paddr (paddr), .pwrite (pwrite), .pstrb (pstrb), .pwdata (pwdata),
    .pprot (pprot), .pready (pready_b), .prdata (prdata_b), .pslverr (pslverr_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    @(posedge clk); #1;
    psel_a  = 1'b0;
    psel_b  = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
  endtask

  task automatic xfer(input bit on_b, input string tag, input logic [31:0] addr, input bit wr,
                      input logic [31:0] data, input logic [3:0] strb, input logic [2:0] prot,
                      input logic [31:0] exp_rdata, input bit exp_err, input int exp_wait);
    exp_t        e;
    exp_t        got;
    int          waits;
    bit          seen;
    logic [31:0] rd;
    logic        er;
    e.tag   = tag;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.waits = exp_wait;
    @(posedge clk); #1;
    psel_a  = on_b ? 1'b0 : 1'b1;
    psel_b  = on_b ? 1'b1 : 1'b0;
    penable = 1'b0;
    paddr   = addr;
    pwrite  = wr;
    pwdata  = data;
    pstrb   = strb;
    pprot   = prot;
    sb_q.push_back(e);
    @(posedge clk); #1;
    penable = 1'b1;
    waits = 0;
    seen  = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if ((on_b ? pready_b : pready_a) === 1'b1) begin
        seen = 1'b1;
      end else begin
        waits++;
        @(posedge clk); #1;
      end
    end
    check({tag, "/pready_seen"}, 32'(seen), 32'd1);
    got = sb_q.pop_front();
    if (seen) begin
      rd = on_b ? prdata_b : prdata_a;
      er = on_b ? pslverr_b : pslverr_a;
      check({got.tag, "/prdata"}, rd, got.rdata);
      check({got.tag, "/pslverr"}, 32'(er), 32'(got.err));
      check({got.tag, "/wait_cycles"}, 32'(waits), 32'(got.waits));
      $display("xfer %-14s dut=%s addr=%h wr=%0d wdata=%h strb=%b prdata=%h pslverr=%0d waits=%0d",
               got.tag, on_b ? "b" : "a", addr, wr, data, strb, rd, er, waits);
    end
  endtask

  initial begin
    preset  = 1'b1;
    psel_a  = 1'b0;
    psel_b  = 1'b0;
    penable = 1'b0;
    paddr   = '0;
    pwrite  = 1'b0;
    pstrb   = '0;
    pwdata  = '0;
    pprot   = 3'b001;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pready_a", 32'(pready_a), 32'd0);
    check("rst_pslverr_a", 32'(pslverr_a), 32'd0);
    check("rst_prdata_a", prdata_a, 32'd0);
    check("rst_pready_b", 32'(pready_b), 32'd0);
    @(posedge clk); #1;
    preset = 1'b0;

    // penable without a setup cycle must not start a transfer
    psel_a  = 1'b1;
    penable = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("no_setup_pready", 32'(pready_a), 32'd0);
    end
    bus_idle();

    xfer(0, "wr_beef", BASE + 4, 1, 32'hDEAD_BEEF, 4'hF, 3'b001, 32'h0, 0, 2);
    xfer(0, "rd_beef", BASE + 4, 0, 32'h0, 4'h0, 3'b001, 32'hDEAD_BEEF, 0, 2);
    xfer(0, "wr_strb0101", BASE + 8, 1, 32'h1122_3344, 4'b0101, 3'b001, 32'h0, 0, 2);
    xfer(0, "rd_strb0101", BASE + 8, 0, 32'h0, 4'h0, 3'b001, 32'h0022_0044, 0, 2);
    bus_idle();

    xfer(0, "rd_past_end", BASE + 64, 0, 32'h0, 4'h0, 3'b001, 32'h0, 1, 2);
    xfer(0, "rd_misalign", BASE + 2, 0, 32'h0, 4'h0, 3'b001, 32'h0, 1, 2);
    xfer(0, "rd_below_base", BASE - 4, 0, 32'h0, 4'h0, 3'b001, 32'h0, 1, 2);
    xfer(0, "wr_misalign", BASE + 6, 1, 32'hFFFF_FFFF, 4'hF, 3'b001, 32'h0, 1, 2);
    xfer(0, "rd_beef_kept", BASE + 4, 0, 32'h0, 4'h0, 3'b001, 32'hDEAD_BEEF, 0, 2);

    xfer(0, "wr_id", BASE + 60, 1, 32'h1234_5678, 4'hF, 3'b001, 32'h0, 1, 2);
    xfer(0, "wr_unpriv", BASE + 0, 1, 32'h0BAD_0BAD, 4'hF, 3'b000, 32'h0, 1, 2);
    xfer(0, "rd_id", BASE + 60, 0, 32'h0, 4'h0, 3'b001, ID_VAL, 0, 2);
    xfer(0, "rd_word0", BASE + 0, 0, 32'h0, 4'h0, 3'b001, 32'h0, 0, 2);
    xfer(0, "wr_nostrb", BASE + 4, 1, 32'h0000_0000, 4'h0, 3'b001, 32'h0, 0, 2);
    xfer(0, "rd_nostrb", BASE + 4, 0, 32'h0, 4'h0, 3'b001, 32'hDEAD_BEEF, 0, 2);
    bus_idle();

    // zero-wait completer, back-to-back write then read
    xfer(1, "b_wr_c", BASE + 12, 1, 32'hCAFE_F00D, 4'hF, 3'b001, 32'h0, 0, 0);
    xfer(1, "b_rd_c", BASE + 12, 0, 32'h0, 4'h0, 3'b001, 32'hCAFE_F00D, 0, 0);
    xfer(1, "b_rd_id", BASE + 60, 0, 32'h0, 4'h0, 3'b001, ID_VAL, 0, 0);
    bus_idle();

    // penable dropped during WAIT aborts the write
    @(posedge clk); #1;
    psel_a = 1'b1; penable = 1'b0; paddr = BASE + 4; pwrite = 1'b1;
    pwdata = 32'h1234_5678; pstrb = 4'hF; pprot = 3'b001;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel_a = 1'b0; penable = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("abort_pready", 32'(pready_a), 32'd0);
    end
    xfer(0, "rd_after_abort", BASE + 4, 0, 32'h0, 4'h0, 3'b001, 32'hDEAD_BEEF, 0, 2);
    bus_idle();

    // reset during WAIT discards the write and clears storage
    @(posedge clk); #1;
    psel_a = 1'b1; penable = 1'b0; paddr = BASE + 4; pwrite = 1'b1;
    pwdata = 32'h55AA_55AA; pstrb = 4'hF; pprot = 3'b001;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    check("rst_mid_pready0", 32'(pready_a), 32'd0);
    @(posedge clk); #1;
    preset = 1'b1;
    @(negedge clk);
    check("rst_mid_pready1", 32'(pready_a), 32'd0);
    @(posedge clk); #1;
    preset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_mid_pready2", 32'(pready_a), 32'd0);
    end
    bus_idle();
    xfer(0, "rd_after_rst", BASE + 4, 0, 32'h0, 4'h0, 3'b001, 32'h0, 0, 2);
    xfer(0, "rd_id_after_rst", BASE + 60, 0, 32'h0, 4'h0, 3'b001, ID_VAL, 0, 2);
    bus_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/apb_slave_mem.md
APB_SLAVE_MEM -- requirements
Module: apb_slave_mem

Interface
REQ-001 The block SHALL have the following parameters, one per line (name, default, meaning):
- ADDRESS_WIDTH, 32, paddr width.
- DATA_WIDTH, 32, pwdata/prdata width.
- NO_OF_SLAVES, 1, pselx width.
- SLAVE_INDEX, 0, pselx bit that selects this completer.
- BASE_ADDR, 32'h0000_0000, byte address of entry 0.
- MEM_DEPTH, 16, number of DATA_WIDTH words.
- WAIT_STATES, 2, access-phase cycles with pready low (0..15).
- ID_VALUE, 32'hA5B0_0001, reset/read value of the read-only last entry.

REQ-002 The block SHALL have the following ports, one per line (name, direction, width, meaning):
- pclk, input, 1, the single clock; all logic on its rising edge.
- preset, input, 1, synchronous, active-high reset.
- pselx, input, NO_OF_SLAVES, completer selects.
- penable, input, 1, access phase.
- paddr, input, ADDRESS_WIDTH, byte address.
- pwrite, input, 1, 1 = write, 0 = read.
- pstrb, input, DATA_WIDTH/8, write byte lanes.
- pwdata, input, DATA_WIDTH, write data.
- pprot, input, 3, protection; bit 0 = privileged.
- pready, output, 1, transfer completion.
- prdata, output, DATA_WIDTH, read data.
- pslverr, output, 1, transfer error.

Function
REQ-003 sel SHALL be pselx[SLAVE_INDEX]; all other pselx bits SHALL be ignored.
REQ-004 The FSM SHALL have three states: IDLE, WAIT and ACCESS. All outputs SHALL be registered.
REQ-005 In IDLE, sel=1 with penable=0 (setup) SHALL capture paddr, pwrite, pstrb, pwdata and pprot.
- If WAIT_STATES=0, the FSM SHALL go to ACCESS.
- Otherwise it SHALL load a counter with WAIT_STATES-1 and go to WAIT.
REQ-006 In WAIT, the counter SHALL decrement each cycle. The FSM SHALL go to ACCESS on the cycle the counter is 0.
REQ-007 pready SHALL be 1 only in ACCESS, so the first access-phase cycle has pready low for exactly WAIT_STATES cycles. ACCESS SHALL always return to IDLE.
REQ-008 A back-to-back setup in the cycle after ACCESS SHALL be accepted from IDLE with no lost cycle.
REQ-009 Decode error SHALL be flagged when paddr < BASE_ADDR, or paddr >= BASE_ADDR+4*MEM_DEPTH, or paddr[1:0] != 0.
REQ-010 Write-protect error SHALL be flagged for a write to entry MEM_DEPTH-1 (ID register), or a write with pprot[0]=0.
REQ-011 pslverr SHALL be 1 in ACCESS when either error is flagged, and 0 in all other states.
REQ-012 An erroring transfer SHALL NOT modify storage, and its prdata SHALL be 0.
REQ-013 A write SHALL update only the byte lanes with pstrb=1, at the clock edge ending ACCESS. pstrb=0 SHALL leave storage unchanged with no error.
REQ-014 A read SHALL present word (paddr-BASE_ADDR)>>2 on prdata during ACCESS. prdata SHALL be 0 in all other states.
REQ-015 If, in WAIT or ACCESS, sel or penable is 0, the transfer SHALL abort: FSM to IDLE, no write, pready=0.
REQ-016 penable=1 observed in IDLE with no preceding setup SHALL be ignored.
REQ-017 A read of a word written in the immediately preceding transfer SHALL return the new data.

Reset
REQ-018 While preset=1 at a pclk edge:
- FSM SHALL go to IDLE and the counter to 0.
- pready, pslverr and prdata SHALL go to 0.
- Entries 0..MEM_DEPTH-2 SHALL be cleared to 0.
- Entry MEM_DEPTH-1 SHALL be set to ID_VALUE.
REQ-019 Reset asserted mid-transfer SHALL discard that transfer with no storage write and no pready pulse.

Structure
REQ-020 ADDRESS_WIDTH, DATA_WIDTH and NO_OF_SLAVES SHALL come from apb_global_pkg. The state typedef apb_slave_state_e SHALL be added to that package.
REQ-021 Storage with byte-lane write and ID entry SHALL be one sub-module, apb_slave_regfile. FSM, decode and error logic SHALL stay in apb_slave_mem.

Verification
REQ-022 Bench SHALL cover the following directed scenarios, one line each (stimulus -> required response):
- WAIT_STATES=2: write 32'hDEAD_BEEF to BASE+4 with pstrb=4'hF, pprot=3'b001 -> pready low 2 cycles then high 1 cycle, pslverr=0; read BASE+4 -> prdata=32'hDEAD_BEEF.
- Write 32'h1122_3344 to BASE+8 with pstrb=4'b0101 over a zeroed word -> read returns 32'h0022_0044.
- Read BASE+64 (MEM_DEPTH=16), then BASE+2 -> pslverr=1 and prdata=0 for both; storage unchanged.
- Write BASE+60 (ID entry), and write BASE+0 with pprot=3'b000 -> pslverr=1 for both; BASE+60 reads 32'hA5B0_0001 and BASE+0 reads 0.
- WAIT_STATES=0, back-to-back write then read of BASE+12 -> each pready in second cycle of transfer; read returns written data.
- preset=1 during WAIT of a write to BASE+4 -> pready never asserts; subsequent read of BASE+4 returns 0.
